// File: rtl/ysyx_22040759_mem_arbiter.sv
// Round-robin arbiter sharing one AXI read master and one AXI write master
// between instruction fetch (read-only) and the load/store unit (read/write).
module ysyx_22040759_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_resp_valid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  mem_req_i,
    input  logic                  mem_wen_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [2:0]            mem_size_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_resp_valid_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,

    output logic                  rd_addr_valid_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [2:0]            rd_size_o,
    input  logic                  rd_data_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,

    output logic                  wr_addr_valid_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [2:0]            wr_size_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic                  wr_data_valid_i,

    output logic                  timeout_o
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_MEM_WR,
        S_RESP
    } state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_MEM
    } owner_e;

    state_e                state_q,      state_d;
    owner_e                last_grant_q, last_grant_d;
    owner_e                owner_q,      owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [2:0]            size_q,       size_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  rd_valid_q,   rd_valid_d;
    logic                  wr_valid_q,   wr_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
    logic                  if_resp_q,    if_resp_d;
    logic                  mem_resp_q,   mem_resp_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  timeout_q,    timeout_d;

    logic                  grant_mem;
    logic                  busy;

    // MEM wins when alone, or on a tie when IF was served last.
    assign grant_mem = mem_req_i && (!if_req_i || (last_grant_q == OWNER_IF));
    assign busy      = (state_q == S_IF_RD) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        rd_valid_d   = rd_valid_q;
        wr_valid_d   = wr_valid_q;
        rdata_d      = rdata_q;
        if_resp_d    = 1'b0;
        mem_resp_d   = 1'b0;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;

        if (busy) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) begin
                timeout_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (if_req_i || mem_req_i) begin
                    cnt_d = '0;
                    if (grant_mem) begin
                        last_grant_d = OWNER_MEM;
                        owner_d      = OWNER_MEM;
                        addr_d       = mem_addr_i;
                        size_d       = mem_size_i;
                        if (mem_wen_i) begin
                            wdata_d    = mem_wdata_i;
                            wr_valid_d = 1'b1;
                            state_d    = S_MEM_WR;
                        end else begin
                            wdata_d    = '0;
                            rd_valid_d = 1'b1;
                            state_d    = S_MEM_RD;
                        end
                    end else begin
                        last_grant_d = OWNER_IF;
                        owner_d      = OWNER_IF;
                        addr_d       = if_addr_i;
                        size_d       = 3'd3;
                        wdata_d      = '0;
                        rd_valid_d   = 1'b1;
                        state_d      = S_IF_RD;
                    end
                end
            end

            S_IF_RD, S_MEM_RD: begin
                if (rd_data_valid_i) begin
                    rdata_d    = rd_data_i;
                    rd_valid_d = 1'b0;
                    if (owner_q == OWNER_IF) begin
                        if_resp_d = 1'b1;
                    end else begin
                        mem_resp_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end

            S_MEM_WR: begin
                if (wr_data_valid_i) begin
                    rdata_d    = '0;
                    wr_valid_d = 1'b0;
                    mem_resp_d = 1'b1;
                    state_d    = S_RESP;
                end
            end

            // The response cycle never arbitrates, so a held request waits for IDLE.
            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                rd_valid_d = 1'b0;
                wr_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWNER_IF;
            owner_q      <= OWNER_IF;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            rd_valid_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            rdata_q      <= '0;
            if_resp_q    <= 1'b0;
            mem_resp_q   <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            rd_valid_q   <= rd_valid_d;
            wr_valid_q   <= wr_valid_d;
            rdata_q      <= rdata_d;
            if_resp_q    <= if_resp_d;
            mem_resp_q   <= mem_resp_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign if_resp_valid_o  = if_resp_q;
    assign if_rdata_o       = rdata_q;
    assign mem_resp_valid_o = mem_resp_q;
    assign mem_rdata_o      = rdata_q;

    assign rd_addr_valid_o  = rd_valid_q;
    assign rd_addr_o        = addr_q;
    assign rd_size_o        = size_q;

    assign wr_addr_valid_o  = wr_valid_q;
    assign wr_addr_o        = addr_q;
    assign wr_size_o        = size_q;
    assign wr_data_o        = wdata_q;

    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the IF/MEM arbiter: each step drives inputs 1 time unit
// after a rising edge and checks the outputs registered by that edge.
module tb_ysyx_22040759_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_resp_valid_o;
    logic [63:0] if_rdata_o;
    logic        mem_req_i;
    logic        mem_wen_i;
    logic [31:0] mem_addr_i;
    logic [2:0]  mem_size_i;
    logic [63:0] mem_wdata_i;
    logic        mem_resp_valid_o;
    logic [63:0] mem_rdata_o;
    logic        rd_addr_valid_o;
    logic [31:0] rd_addr_o;
    logic [2:0]  rd_size_o;
    logic        rd_data_valid_i;
    logic [63:0] rd_data_i;
    logic        wr_addr_valid_o;
    logic [31:0] wr_addr_o;
    logic [2:0]  wr_size_o;
    logic [63:0] wr_data_o;
    logic        wr_data_valid_i;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    ysyx_22040759_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_resp_valid_o (if_resp_valid_o),
        .if_rdata_o      (if_rdata_o),
        .mem_req_i       (mem_req_i),
        .mem_wen_i       (mem_wen_i),
        .mem_addr_i      (mem_addr_i),
        .mem_size_i      (mem_size_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_resp_valid_o(mem_resp_valid_o),
        .mem_rdata_o     (mem_rdata_o),
        .rd_addr_valid_o (rd_addr_valid_o),
        .rd_addr_o       (rd_addr_o),
        .rd_size_o       (rd_size_o),
        .rd_data_valid_i (rd_data_valid_i),
        .rd_data_i       (rd_data_i),
        .wr_addr_valid_o (wr_addr_valid_o),
        .wr_addr_o       (wr_addr_o),
        .wr_size_o       (wr_size_o),
        .wr_data_o       (wr_data_o),
        .wr_data_valid_i (wr_data_valid_i),
        .timeout_o       (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        if_req_i        = 1'b0;
        if_addr_i       = '0;
        mem_req_i       = 1'b0;
        mem_wen_i       = 1'b0;
        mem_addr_i      = '0;
        mem_size_i      = '0;
        mem_wdata_i     = '0;
        rd_data_valid_i = 1'b0;
        rd_data_i       = '0;
        wr_data_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rd_valid", 64'(rd_addr_valid_o), 64'd0);
        check("rst_wr_valid", 64'(wr_addr_valid_o), 64'd0);
        check("rst_if_resp", 64'(if_resp_valid_o), 64'd0);
        check("rst_mem_resp", 64'(mem_resp_valid_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        check("rst_rd_size", 64'(rd_size_o), 64'd0);
        check("rst_wr_data", wr_data_o, 64'd0);

        // First tie after reset: MEM read wins, then IF
        if_req_i   = 1'b1;
        if_addr_i  = 32'h8000_0000;
        mem_req_i  = 1'b1;
        mem_wen_i  = 1'b0;
        mem_addr_i = 32'h8000_1000;
        mem_size_i = 3'd3;
        tick();                                            // c1
        check("tie_mem_valid", 64'(rd_addr_valid_o), 64'd1);
        check("tie_mem_addr", 64'(rd_addr_o), 64'h8000_1000);
        tick();                                            // c2
        tick();                                            // c3
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'h1111_2222_3333_4444;
        tick();                                            // c4
        rd_data_valid_i = 1'b0;
        check("tie_mem_resp", 64'(mem_resp_valid_o), 64'd1);
        check("tie_mem_rdata", mem_rdata_o, 64'h1111_2222_3333_4444);
        check("tie_if_resp_low", 64'(if_resp_valid_o), 64'd0);
        mem_req_i = 1'b0;
        tick();                                            // c5
        check("tie_gap_valid", 64'(rd_addr_valid_o), 64'd0);
        tick();                                            // c6
        check("tie_if_valid", 64'(rd_addr_valid_o), 64'd1);
        check("tie_if_addr", 64'(rd_addr_o), 64'h8000_0000);
        check("tie_if_size", 64'(rd_size_o), 64'd3);
        tick();                                            // c7
        tick();                                            // c8
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'h5555_6666_7777_8888;
        tick();                                            // c9
        rd_data_valid_i = 1'b0;
        check("tie_if_resp", 64'(if_resp_valid_o), 64'd1);
        check("tie_if_rdata", if_rdata_o, 64'h5555_6666_7777_8888);
        if_req_i = 1'b0;
        tick();

        // IF read completing in cycle 3
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0000;
        tick();                                            // c1
        check("if_c1_valid", 64'(rd_addr_valid_o), 64'd1);
        check("if_c1_size", 64'(rd_size_o), 64'd3);
        check("if_c1_addr", 64'(rd_addr_o), 64'h8000_0000);
        check("if_c1_wr_valid", 64'(wr_addr_valid_o), 64'd0);
        tick();                                            // c2
        check("if_c2_size", 64'(rd_size_o), 64'd3);
        check("if_c2_resp", 64'(if_resp_valid_o), 64'd0);
        tick();                                            // c3
        check("if_c3_valid", 64'(rd_addr_valid_o), 64'd1);
        check("if_c3_size", 64'(rd_size_o), 64'd3);
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'h0000_0013_0000_0093;
        tick();                                            // c4
        rd_data_valid_i = 1'b0;
        check("if_c4_valid", 64'(rd_addr_valid_o), 64'd0);
        check("if_c4_resp", 64'(if_resp_valid_o), 64'd1);
        check("if_c4_rdata", if_rdata_o, 64'h0000_0013_0000_0093);
        check("if_c4_mem_resp", 64'(mem_resp_valid_o), 64'd0);
        if_req_i = 1'b0;
        tick();                                            // c5
        check("if_c5_resp", 64'(if_resp_valid_o), 64'd0);

        // MEM store word; inputs change mid-transaction
        mem_req_i   = 1'b1;
        mem_wen_i   = 1'b1;
        mem_addr_i  = 32'h8000_0104;
        mem_size_i  = 3'd2;
        mem_wdata_i = 64'h0000_0000_DEAD_BEEF;
        tick();                                            // c1
        check("sw_c1_valid", 64'(wr_addr_valid_o), 64'd1);
        check("sw_c1_addr", 64'(wr_addr_o), 64'h8000_0104);
        check("sw_c1_size", 64'(wr_size_o), 64'd2);
        check("sw_c1_data", wr_data_o, 64'h0000_0000_DEAD_BEEF);
        check("sw_c1_rd_valid", 64'(rd_addr_valid_o), 64'd0);
        mem_addr_i      = 32'h0000_1234;
        mem_size_i      = 3'd0;
        mem_wdata_i     = 64'h0;
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();                                            // c2
        rd_data_valid_i = 1'b0;
        check("sw_ignore_rd_pulse", 64'(wr_addr_valid_o), 64'd1);
        check("sw_c2_mem_resp", 64'(mem_resp_valid_o), 64'd0);
        check("sw_c2_addr", 64'(wr_addr_o), 64'h8000_0104);
        check("sw_c2_size", 64'(wr_size_o), 64'd2);
        check("sw_c2_data", wr_data_o, 64'h0000_0000_DEAD_BEEF);
        wr_data_valid_i = 1'b1;
        tick();                                            // c3
        wr_data_valid_i = 1'b0;
        check("sw_c3_valid", 64'(wr_addr_valid_o), 64'd0);
        check("sw_c3_resp", 64'(mem_resp_valid_o), 64'd1);
        check("sw_c3_rdata", mem_rdata_o, 64'd0);
        check("sw_c3_rd_valid", 64'(rd_addr_valid_o), 64'd0);
        mem_req_i = 1'b0;
        mem_wen_i = 1'b0;
        tick();                                            // c4 IDLE
        check("sw_c4_resp", 64'(mem_resp_valid_o), 64'd0);
        rd_data_valid_i = 1'b1;
        wr_data_valid_i = 1'b1;
        tick();                                            // c5
        rd_data_valid_i = 1'b0;
        wr_data_valid_i = 1'b0;
        check("idle_pulse_if_resp", 64'(if_resp_valid_o), 64'd0);
        check("idle_pulse_mem_resp", 64'(mem_resp_valid_o), 64'd0);
        check("idle_pulse_rd_valid", 64'(rd_addr_valid_o), 64'd0);

        // Back-to-back IF with req held, best-case completion
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0200;
        tick();                                            // c1
        check("b2b_c1_valid", 64'(rd_addr_valid_o), 64'd1);
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'hA5A5_A5A5_0000_0001;
        tick();                                            // c2
        rd_data_valid_i = 1'b0;
        check("b2b_c2_resp", 64'(if_resp_valid_o), 64'd1);
        check("b2b_c2_rdata", if_rdata_o, 64'hA5A5_A5A5_0000_0001);
        check("b2b_c2_valid", 64'(rd_addr_valid_o), 64'd0);
        if_addr_i = 32'h8000_0208;
        tick();                                            // c3
        check("b2b_c3_valid", 64'(rd_addr_valid_o), 64'd0);
        check("b2b_c3_resp", 64'(if_resp_valid_o), 64'd0);
        tick();                                            // c4
        check("b2b_c4_valid", 64'(rd_addr_valid_o), 64'd1);
        check("b2b_c4_addr", 64'(rd_addr_o), 64'h8000_0208);
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'hA5A5_A5A5_0000_0002;
        tick();                                            // c5
        rd_data_valid_i = 1'b0;
        check("b2b_c5_resp", 64'(if_resp_valid_o), 64'd1);
        check("b2b_c5_rdata", if_rdata_o, 64'hA5A5_A5A5_0000_0002);
        if_req_i = 1'b0;
        tick();                                            // c6
        check("b2b_c6_resp", 64'(if_resp_valid_o), 64'd0);
        tick();                                            // c7
        check("b2b_c7_valid", 64'(rd_addr_valid_o), 64'd0);

        // Timeout with TIMEOUT_CYCLES = 8; late completion still answered
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0300;
        tick();                                            // c1
        check("to_c1_timeout", 64'(timeout_o), 64'd0);
        for (int i = 2; i <= 8; i++) begin
            tick();                                        // c2..c8
        end
        check("to_c8_timeout", 64'(timeout_o), 64'd0);
        check("to_c8_valid", 64'(rd_addr_valid_o), 64'd1);
        tick();                                            // c9
        check("to_c9_timeout", 64'(timeout_o), 64'd1);
        tick();                                            // c10
        check("to_c10_timeout", 64'(timeout_o), 64'd1);
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'h0BAD_F00D_0000_0000;
        tick();                                            // c11
        rd_data_valid_i = 1'b0;
        check("to_c11_resp", 64'(if_resp_valid_o), 64'd1);
        check("to_c11_rdata", if_rdata_o, 64'h0BAD_F00D_0000_0000);
        if_req_i = 1'b0;
        tick();                                            // c12
        check("to_c12_resp", 64'(if_resp_valid_o), 64'd0);
        check("to_c12_sticky", 64'(timeout_o), 64'd1);

        // Reset during MEM_WR
        mem_req_i   = 1'b1;
        mem_wen_i   = 1'b1;
        mem_addr_i  = 32'h8000_0400;
        mem_size_i  = 3'd3;
        mem_wdata_i = 64'h0123_4567_89AB_CDEF;
        tick();                                            // c1
        check("rstw_c1_valid", 64'(wr_addr_valid_o), 64'd1);
        rst = 1'b1;
        tick();                                            // c2
        check("rstw_c2_wr_valid", 64'(wr_addr_valid_o), 64'd0);
        check("rstw_c2_rd_valid", 64'(rd_addr_valid_o), 64'd0);
        check("rstw_c2_timeout", 64'(timeout_o), 64'd0);
        check("rstw_c2_wr_addr", 64'(wr_addr_o), 64'd0);
        rst       = 1'b0;
        mem_req_i = 1'b0;
        mem_wen_i = 1'b0;
        tick();                                            // c3
        wr_data_valid_i = 1'b1;
        tick();                                            // c4
        wr_data_valid_i = 1'b0;
        check("rstw_c4_mem_resp", 64'(mem_resp_valid_o), 64'd0);
        check("rstw_c4_wr_valid", 64'(wr_addr_valid_o), 64'd0);

        // Tie after reset goes to MEM again
        if_req_i   = 1'b1;
        if_addr_i  = 32'h8000_0500;
        mem_req_i  = 1'b1;
        mem_wen_i  = 1'b0;
        mem_addr_i = 32'h8000_2000;
        mem_size_i = 3'd1;
        tick();                                            // c5
        check("rstw_tie_valid", 64'(rd_addr_valid_o), 64'd1);
        check("rstw_tie_addr", 64'(rd_addr_o), 64'h8000_2000);
        check("rstw_tie_size", 64'(rd_size_o), 64'd1);
        rd_data_valid_i = 1'b1;
        rd_data_i       = 64'h0000_0000_0000_BEEF;
        tick();                                            // c6
        rd_data_valid_i = 1'b0;
        check("rstw_tie_mem_resp", 64'(mem_resp_valid_o), 64'd1);
        check("rstw_tie_if_resp", 64'(if_resp_valid_o), 64'd0);
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
